// File: rtl/mp_serial_adder.sv
// ---------------------------------------------------------------------------
// mp_serial_adder
//
// Multi-precision operand sequencer. Adds two OP_W-bit operands over NCHUNK
// cycles using a single CHUNK_W-bit adder slice, with the carry registered
// between chunks. Valid/ready handshakes on both the operand and the result
// side. Trades latency for area when OP_W is wider than one adder instance.
//
// Optional feature macro: MPADD_SUB_EN
//   defined   -> in_sub port present; subtraction computed as A + ~B + ~cin
//   undefined -> add-only build, no in_sub port and no inverter logic
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand set valid
//   in_ready   out  1      high only while idle
//   in_a       in   OP_W   operand A
//   in_b       in   OP_W   operand B
//   in_cin     in   1      carry-in (borrow-in when subtracting)
//   in_sub     in   1      subtract select (MPADD_SUB_EN builds only)
//   out_valid  out  1      result valid, held until accepted
//   out_ready  in   1      downstream accepts result
//   out_sum    out  OP_W   result
//   out_cout   out  1      carry-out of the most significant chunk
// ---------------------------------------------------------------------------
module mp_serial_adder #(
    parameter int OP_W    = 64,
    parameter int CHUNK_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    input  logic            in_cin,
`ifdef MPADD_SUB_EN
    input  logic            in_sub,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_sum,
    output logic            out_cout
);

    localparam int NCHUNK = OP_W / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Operand width must split evenly into adder slices.
    generate
        if ((CHUNK_W < 1) || ((OP_W % CHUNK_W) != 0)) begin : g_badWidth
            $error("mp_serial_adder: OP_W must be an integer multiple of CHUNK_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic [OP_W-1:0]    r_sum;
    logic [OP_W-1:0]    r_outSum;
    logic               r_carry;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;

    logic [31:0]        w_base;
    logic [CHUNK_W:0]   w_chunkSum;
    logic [OP_W-1:0]    w_nextSum;
    logic               w_lastChunk;
    logic [OP_W-1:0]    w_latchB;
    logic               w_latchCarry;

    // Subtraction folds into the same adder: B is stored inverted and the
    // carry-in inverted, so A + ~B + ~cin = A - B - cin modulo 2^OP_W.
`ifdef MPADD_SUB_EN
    assign w_latchB     = in_sub ? ~in_b : in_b;
    assign w_latchCarry = in_sub ^ in_cin;
`else
    assign w_latchB     = in_b;
    assign w_latchCarry = in_cin;
`endif

    // Bit offset of the chunk being processed this cycle.
    assign w_base      = 32'(r_idx) * 32'(CHUNK_W);
    assign w_lastChunk = (r_idx == IDX_W'(NCHUNK - 1));

    // One slice of addition: the extra top bit is the chunk carry-out.
    assign w_chunkSum = {1'b0, r_a[w_base +: CHUNK_W]}
                      + {1'b0, r_b[w_base +: CHUNK_W]}
                      + {{CHUNK_W{1'b0}}, r_carry};

    // Working sum with the current chunk merged in; on the last chunk this
    // is the complete result handed to the output register.
    always_comb begin
        w_nextSum = r_sum;
        w_nextSum[w_base +: CHUNK_W] = w_chunkSum[CHUNK_W-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: accept only in IDLE, run NCHUNK slices, then hold
    // the result until downstream takes it.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)    w_nextState = RUN;
            RUN:     if (w_lastChunk) w_nextState = DONE;
            DONE:    if (out_ready)   w_nextState = IDLE;
            default:                  w_nextState = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Datapath. The visible result lives in a separate register so it keeps
    // the previous answer until the final chunk of the next op is produced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_outSum <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_idx    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= w_latchB;
                        r_carry <= w_latchCarry;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= w_nextSum;
                    r_carry <= w_chunkSum[CHUNK_W];
                    if (w_lastChunk) begin
                        r_outSum <= w_nextSum;
                        r_cout   <= w_chunkSum[CHUNK_W];
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                default: begin
                    r_idx   <= '0;
                    r_carry <= 1'b0;
                end
            endcase
        end
    end

    assign out_sum  = r_outSum;
    assign out_cout = r_cout;

endmodule

// File: tb/tb_mp_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_mp_serial_adder
//
// Self-checking bench for mp_serial_adder (OP_W=64, CHUNK_W=16). Directed
// cases cover ripple carry, mixed chunks, backpressure, mid-run reset and
// (with MPADD_SUB_EN) subtraction; then a randomized stream of operations
// with random handshake gaps is checked against an integer-arithmetic model
// through a queue of expected results.
// ---------------------------------------------------------------------------
module tb_mp_serial_adder;

    localparam int OP_W    = 64;
    localparam int CHUNK_W = 16;
    localparam int NCHUNK  = OP_W / CHUNK_W;
    localparam int NRAND   = 2000;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_a;
    logic [OP_W-1:0] in_b;
    logic            in_cin;
    logic            in_sub;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_sum;
    logic            out_cout;

    int assertCount = 0;
    int failCount   = 0;

    mp_serial_adder #(
        .OP_W    (OP_W),
        .CHUNK_W (CHUNK_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef MPADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on 65-bit values. For subtraction
    // the carry-out is "no borrow", i.e. A >= B + cin.
    function automatic logic [OP_W:0] refModel(input logic [OP_W-1:0] a,
                                               input logic [OP_W-1:0] b,
                                               input logic cin,
                                               input logic sub);
        logic [OP_W:0] full;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b} - {{OP_W{1'b0}}, cin};
            return {({1'b0, a} >= ({1'b0, b} + {{OP_W{1'b0}}, cin})), full[OP_W-1:0]};
        end
        full = {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, cin};
        return full;
    endfunction

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag,
                               input logic [OP_W-1:0] observed,
                               input logic [OP_W-1:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present one operand set from a negedge and hold it until accepted.
    task automatic applyStimulus(input logic [OP_W-1:0] a,
                                 input logic [OP_W-1:0] b,
                                 input logic cin,
                                 input logic sub);
        int waitCnt;
        waitCnt  = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("accept ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Full directed transaction: accept, measure latency, check result,
    // retire it. holdReady keeps out_ready high during RUN as well.
    task automatic runOp(input string tag,
                         input logic [OP_W-1:0] a,
                         input logic [OP_W-1:0] b,
                         input logic cin,
                         input logic sub,
                         input logic holdReady);
        logic [OP_W:0] expd;
        int lat;
        expd      = refModel(a, b, cin, sub);
        out_ready = holdReady;
        applyStimulus(a, b, cin, sub);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(NCHUNK));
        checkOutput({tag, " sum"}, out_sum, expd[OP_W-1:0]);
        checkOutput({tag, " cout"}, {63'd0, out_cout}, {63'd0, expd[OP_W]});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, " released"}, {63'd0, out_valid}, 64'd0);
    endtask

    logic [OP_W:0] expQ[$];

    initial begin
        logic [OP_W:0] expd;
        int sent;
        int recv;
        int cycles;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset out_sum", out_sum, 64'd0);
        checkOutput("reset out_cout", {63'd0, out_cout}, 64'd0);

        // Carry ripples through every chunk.
        runOp("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("ripple literal", out_sum, 64'd0);

        // Independent chunks with carry-in; out_ready held high through RUN.
        runOp("chunks", 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, 1'b1);
        checkOutput("chunks literal", out_sum, 64'h0011_0022_0033_0045);

        // Backpressure: result must stay put, new operands must be ignored.
        expd = refModel(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        out_ready = 1'b0;
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        repeat (NCHUNK) @(negedge clk);
        checkOutput("bp valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b1;
        in_a     = 64'hAAAA_AAAA_AAAA_AAAA;
        in_b     = 64'h5555_5555_5555_5555;
        in_cin   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp sum", out_sum, expd[OP_W-1:0]);
            checkOutput("bp in_ready", {63'd0, in_ready}, 64'd0);
        end
        checkOutput("bp cout", {63'd0, out_cout}, {63'd0, expd[OP_W]});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp idle", {63'd0, in_ready}, 64'd1);
        repeat (NCHUNK + 3) @(negedge clk);
        checkOutput("bp no second result", {63'd0, out_valid}, 64'd0);
        checkOutput("bp sum kept", out_sum, expd[OP_W-1:0]);

        // Reset while the third chunk is pending.
        in_a     = 64'h0123_4567_89AB_CDEF;
        in_b     = 64'hFEDC_BA98_7654_3210;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midreset in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("midreset out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midreset out_sum", out_sum, 64'd0);
        checkOutput("midreset out_cout", {63'd0, out_cout}, 64'd0);
        runOp("after reset", 64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
        checkOutput("after reset literal", out_sum, 64'd7);

`ifdef MPADD_SUB_EN
        runOp("sub borrow", 64'd5, 64'd7, 1'b0, 1'b1, 1'b0);
        checkOutput("sub borrow literal", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("sub borrow cout", {63'd0, out_cout}, 64'd0);
        runOp("sub noborrow", 64'd7, 64'd5, 1'b0, 1'b1, 1'b0);
        checkOutput("sub noborrow literal", out_sum, 64'd2);
        checkOutput("sub noborrow cout", {63'd0, out_cout}, 64'd1);
`endif

        // Random stream: inputs change each negedge, handshakes are judged
        // from the values visible at that negedge (they fire on the next edge).
        sent   = 0;
        recv   = 0;
        cycles = 0;
        while (recv < NRAND && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0:       in_a = '1;
                1:       in_a = '0;
                default: in_a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 7))
                0:       in_b = '1;
                1:       in_b = 64'd1;
                default: in_b = {$urandom, $urandom};
            endcase
            in_cin = 1'($urandom_range(0, 1));
`ifdef MPADD_SUB_EN
            in_sub = 1'($urandom_range(0, 1));
`else
            in_sub = 1'b0;
`endif
            if (in_valid && in_ready) begin
                expQ.push_back(refModel(in_a, in_b, in_cin, in_sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("rand unexpected result", {63'd0, out_valid}, 64'd0);
                end else begin
                    expd = expQ.pop_front();
                    checkOutput("rand sum", out_sum, expd[OP_W-1:0]);
                    checkOutput("rand cout", {63'd0, out_cout}, {63'd0, expd[OP_W]});
                end
                recv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("rand results received", 64'(recv), 64'(NRAND));
        checkOutput("rand queue drained", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
